// File: rtl/hdmi_mode_pkg.sv
// Shared types and constants for the HDMI mode-switch controller.
package hdmi_mode_pkg;

    // Reconfiguration sequencer states.
    typedef enum logic [2:0] {
        StIdle,
        StBlank,
        StReq,
        StWaitAck,
        StUnblank
    } state_e;

    // Avalon-MM word addresses; address 3 is reserved.
    localparam logic [1:0] ADDR_STATUS  = 2'd0;
    localparam logic [1:0] ADDR_CONTROL = 2'd1;
    localparam logic [1:0] ADDR_CLEAR   = 2'd2;

    // STATUS register field positions.
    localparam int unsigned STATUS_SYNC_LSB   = 0;
    localparam int unsigned STATUS_STABLE_LSB = 4;
    localparam int unsigned STATUS_ACTIVE_LSB = 8;
    localparam int unsigned STATUS_BUSY_BIT   = 16;
    localparam int unsigned STATUS_ERROR_BIT  = 17;
    localparam int unsigned STATUS_IRQ_BIT    = 18;

endpackage

// File: rtl/hdmi_mode_ctrl_if.sv
// Bundle of the HPS register bus, mode pins and video-config handshake.
interface hdmi_mode_ctrl_if;

    logic [3:0]  mode_in;
    logic [1:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;
    logic        irq;
    logic [3:0]  cfg_mode;
    logic        cfg_req;
    logic        cfg_ack;
    logic        video_blank;

    // Controller side.
    modport slave (
        input  mode_in,
        input  avs_address,
        input  avs_read,
        input  avs_write,
        input  avs_writedata,
        input  cfg_ack,
        output avs_readdata,
        output irq,
        output cfg_mode,
        output cfg_req,
        output video_blank
    );

    // Host / video-config side.
    modport master (
        output mode_in,
        output avs_address,
        output avs_read,
        output avs_write,
        output avs_writedata,
        output cfg_ack,
        input  avs_readdata,
        input  irq,
        input  cfg_mode,
        input  cfg_req,
        input  video_blank
    );

endinterface

// File: rtl/mode_debounce.sv
// Two-flop synchroniser plus debounce filter for the raw mode pins.
module mode_debounce
    import hdmi_mode_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] mode_i,
    output logic [3:0] mode_sync_o,
    output logic [3:0] stable_mode_o
);

    localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

    logic [3:0]      sync1_q, sync2_q;
    logic [3:0]      cand_q, cand_d;
    logic [3:0]      stable_q, stable_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    // Restart the hold count on any change; accept the candidate on the same
    // edge the count reaches its last value so pin-to-stable is 2 + DEBOUNCE_CYCLES.
    always_comb begin
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        stable_d = stable_q;
        if (sync2_q != cand_q) begin
            cand_d = sync2_q;
            cnt_d  = '0;
        end else begin
            if (cnt_q != CntMax) begin
                cnt_d = cnt_q + 1'b1;
            end
            if (cnt_d == CntMax) begin
                stable_d = cand_q;
            end
        end
    end

    // Synchroniser and debounce state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            cand_q   <= '0;
            cnt_q    <= '0;
            stable_q <= '0;
        end else begin
            sync1_q  <= mode_i;
            sync2_q  <= sync1_q;
            cand_q   <= cand_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

    assign mode_sync_o   = sync2_q;
    assign stable_mode_o = stable_q;

endmodule

// File: rtl/hdmi_mode_ctrl.sv
// HDMI mode-switch controller: debounced mode detection, blank/request/ack
// reconfiguration sequencer and Avalon-MM status/control registers.
module hdmi_mode_ctrl
    import hdmi_mode_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned TIMEOUT_CYCLES  = 1000000
) (
    input logic              clk,
    input logic              reset,
    hdmi_mode_ctrl_if.slave  bus_io
);

    localparam int unsigned TmoW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TmoW-1:0] TmoMax = TmoW'(TIMEOUT_CYCLES - 1);

    state_e          state_q, state_d;
    logic [TmoW-1:0] tmo_q, tmo_d;
    logic [3:0]      cfg_mode_q, cfg_mode_d;
    logic [3:0]      active_q, active_d;
    logic            enable_q, enable_d;
    logic            irq_en_q, irq_en_d;
    logic            pend_q, pend_d;
    logic            error_q, error_d;
    logic [31:0]     rdata_q, rdata_d;
    logic [31:0]     status;
    logic [3:0]      mode_sync;
    logic [3:0]      stable_mode;
    logic            ack_evt;
    logic            tmo_evt;
    logic            wr_ctrl;
    logic            wr_clr;
    logic            unused_wdata;

    mode_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk           (clk),
        .reset         (reset),
        .mode_i        (bus_io.mode_in),
        .mode_sync_o   (mode_sync),
        .stable_mode_o (stable_mode)
    );

    // Sequencer next state; an ack on the final timeout cycle still counts as success.
    always_comb begin
        state_d = state_q;
        ack_evt = 1'b0;
        tmo_evt = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (stable_mode != active_q && enable_q && !error_q) begin
                    state_d = StBlank;
                end
            end
            StBlank:   state_d = StReq;
            StReq:     state_d = StWaitAck;
            StWaitAck: begin
                if (bus_io.cfg_ack) begin
                    state_d = StUnblank;
                    ack_evt = 1'b1;
                end else if (tmo_q == TmoMax) begin
                    state_d = StUnblank;
                    tmo_evt = 1'b1;
                end
            end
            StUnblank: state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // Datapath and register-file next state; set events beat W1C clears.
    always_comb begin
        wr_ctrl    = bus_io.avs_write && (bus_io.avs_address == ADDR_CONTROL);
        wr_clr     = bus_io.avs_write && (bus_io.avs_address == ADDR_CLEAR);
        tmo_d      = (state_q == StWaitAck) ? tmo_q + 1'b1 : '0;
        cfg_mode_d = (state_q == StBlank) ? stable_mode : cfg_mode_q;
        active_d   = ack_evt ? cfg_mode_q : active_q;
        enable_d   = wr_ctrl ? bus_io.avs_writedata[0] : enable_q;
        irq_en_d   = wr_ctrl ? bus_io.avs_writedata[1] : irq_en_q;
        pend_d     = (pend_q & ~(wr_clr & bus_io.avs_writedata[0])) | ack_evt;
        error_d    = (error_q & ~(wr_clr & bus_io.avs_writedata[1])) | tmo_evt;

        status                             = '0;
        status[STATUS_SYNC_LSB +: 4]       = mode_sync;
        status[STATUS_STABLE_LSB +: 4]     = stable_mode;
        status[STATUS_ACTIVE_LSB +: 4]     = active_q;
        status[STATUS_BUSY_BIT]            = (state_q != StIdle);
        status[STATUS_ERROR_BIT]           = error_q;
        status[STATUS_IRQ_BIT]             = pend_q;

        rdata_d = rdata_q;
        if (bus_io.avs_read) begin
            case (bus_io.avs_address)
                ADDR_STATUS:  rdata_d = status;
                ADDR_CONTROL: rdata_d = {30'b0, irq_en_q, enable_q};
                default:      rdata_d = '0;
            endcase
        end
    end

    // Sequencer state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Timeout counter, mode registers and register file.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_q      <= '0;
            cfg_mode_q <= '0;
            active_q   <= '0;
            enable_q   <= 1'b1;
            irq_en_q   <= 1'b0;
            pend_q     <= 1'b0;
            error_q    <= 1'b0;
            rdata_q    <= '0;
        end else begin
            tmo_q      <= tmo_d;
            cfg_mode_q <= cfg_mode_d;
            active_q   <= active_d;
            enable_q   <= enable_d;
            irq_en_q   <= irq_en_d;
            pend_q     <= pend_d;
            error_q    <= error_d;
            rdata_q    <= rdata_d;
        end
    end

    // Handshake outputs decode straight from state so reset drops them at once.
    assign bus_io.video_blank  = (state_q != StIdle);
    assign bus_io.cfg_req      = (state_q == StReq) || (state_q == StWaitAck);
    assign bus_io.cfg_mode     = cfg_mode_q;
    assign bus_io.irq          = pend_q & irq_en_q;
    assign bus_io.avs_readdata = rdata_q;

    assign unused_wdata = ^bus_io.avs_writedata[31:2];

endmodule

// File: tb/tb_hdmi_mode_ctrl.sv
// Scoreboard bench for hdmi_mode_ctrl with a transaction-level reference model.
module tb_hdmi_mode_ctrl;

    localparam int unsigned D = 16;
    localparam int unsigned T = 40;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    hdmi_mode_ctrl_if bus ();

    hdmi_mode_ctrl #(
        .DEBOUNCE_CYCLES (D),
        .TIMEOUT_CYCLES  (T)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .bus_io (bus)
    );

    int checks = 0;
    int errors = 0;
    int req_rises = 0;

    logic [31:0] rd_exp_q[$];
    logic [31:0] rd_mask_q[$];
    logic [3:0]  req_exp_q[$];

    // Reference model of the architecturally visible state, valid when quiescent.
    logic [3:0] m_pins, m_stable, m_active;
    bit         m_error, m_pend, m_irq_en;

    bit ack_auto  = 1'b1;
    int ack_dly   = 3;
    bit stray_ack = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual timeout required event", name);
    endtask

    function automatic logic [31:0] status_exp();
        return 32'(m_pins) | (32'(m_stable) << 4) | (32'(m_active) << 8) |
               (32'(m_error) << 17) | (32'(m_pend) << 18);
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic rd(input logic [1:0] addr, input logic [31:0] exp,
                      input logic [31:0] mask = 32'hFFFF_FFFF);
        @(negedge clk);
        bus.avs_address = addr;
        bus.avs_read    = 1'b1;
        rd_exp_q.push_back(exp);
        rd_mask_q.push_back(mask);
        @(negedge clk);
        bus.avs_read = 1'b0;
    endtask

    task automatic wr(input logic [1:0] addr, input logic [31:0] data);
        @(negedge clk);
        bus.avs_address   = addr;
        bus.avs_writedata = data;
        bus.avs_write     = 1'b1;
        @(negedge clk);
        bus.avs_write = 1'b0;
    endtask

    task automatic set_mode(input logic [3:0] m);
        @(negedge clk);
        bus.mode_in = m;
        m_pins      = m;
    endtask

    task automatic wait_req(input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(posedge clk);
            #1;
            if (bus.cfg_req) seen = 1'b1;
        end
        if (!seen) fail("req_wait");
    endtask

    task automatic wait_quiet(input int budget);
        int quiet = 0;
        repeat (D + 6) @(negedge clk);
        for (int i = 0; i < budget && quiet < 4; i++) begin
            @(negedge clk);
            if (!bus.video_blank && req_exp_q.size() == 0) quiet++;
            else quiet = 0;
        end
        if (quiet < 4) fail("quiet_wait");
    endtask

    // Video-config responder: ack ack_dly cycles after cfg_req rises.
    initial begin
        int ack_cnt = 0;
        bus.cfg_ack = 1'b0;
        forever begin
            @(negedge clk);
            bus.cfg_ack = 1'b0;
            if (stray_ack) begin
                bus.cfg_ack = 1'b1;
                stray_ack   = 1'b0;
            end else if (bus.cfg_req && ack_auto) begin
                ack_cnt++;
                if (ack_cnt == ack_dly) bus.cfg_ack = 1'b1;
            end else if (!bus.cfg_req) begin
                ack_cnt = 0;
            end
        end
    end

    // Monitor: read data, request events and ack-response timing.
    initial begin
        logic       req_prev = 1'b0;
        logic       blank_chk = 1'b0;
        logic [3:0] held = '0;
        logic [31:0] e, m;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                req_prev  = 1'b0;
                blank_chk = 1'b0;
            end else begin
                if (blank_chk) begin
                    check("blank_after_unblank", 32'(bus.video_blank), 32'd0);
                    blank_chk = 1'b0;
                end
                if (bus.avs_read) begin
                    if (rd_exp_q.size() == 0) begin
                        fail("rd_unexpected");
                    end else begin
                        e = rd_exp_q.pop_front();
                        m = rd_mask_q.pop_front();
                        check("rdata", bus.avs_readdata & m, e & m);
                    end
                end
                if (bus.cfg_ack && req_prev) begin
                    check("ack_req_drop", 32'(bus.cfg_req), 32'd0);
                    check("ack_blank_held", 32'(bus.video_blank), 32'd1);
                    check("ack_irq", 32'(bus.irq), 32'(m_irq_en));
                    blank_chk = 1'b1;
                end
                if (bus.cfg_req && !req_prev) begin
                    req_rises++;
                    check("req_blank_lead", 32'(bus.video_blank), 32'd1);
                    if (req_exp_q.size() == 0) begin
                        check("req_unexpected", 32'(bus.cfg_mode), 32'hFFFF_FFFF);
                    end else begin
                        check("req_mode", 32'(bus.cfg_mode), 32'(req_exp_q.pop_front()));
                    end
                    held = bus.cfg_mode;
                end else if (bus.cfg_req) begin
                    check("mode_held", 32'(bus.cfg_mode), 32'(held));
                end
                req_prev = bus.cfg_req;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual running required finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        int          dur;
        int          r0;
        logic [3:0]  nm;
        bit          ie;

        reset             = 1'b1;
        bus.mode_in       = '0;
        bus.avs_address   = '0;
        bus.avs_read      = 1'b0;
        bus.avs_write     = 1'b0;
        bus.avs_writedata = '0;
        m_pins = '0; m_stable = '0; m_active = '0;
        m_error = 1'b0; m_pend = 1'b0; m_irq_en = 1'b0;

        cyc(3);
        check("rst_rdata", bus.avs_readdata, 32'd0);
        check("rst_irq", 32'(bus.irq), 32'd0);
        check("rst_blank", 32'(bus.video_blank), 32'd0);
        check("rst_req", 32'(bus.cfg_req), 32'd0);
        check("rst_cfg_mode", 32'(bus.cfg_mode), 32'd0);
        reset = 1'b0;
        rd(2'd0, status_exp());
        rd(2'd1, 32'd1);
        rd(2'd2, 32'd0);
        rd(2'd3, 32'd0);

        // First change: latency from pin to cfg_req.
        req_exp_q.push_back(4'd5);
        set_mode(4'd5);
        lat = 0;
        for (int k = 1; k <= int'(D) + 30 && lat == 0; k++) begin
            @(posedge clk);
            #1;
            if (bus.cfg_req) lat = k;
        end
        check("req_latency", 32'(lat), 32'(D + 4));
        wait_quiet(200);
        m_stable = 4'd5; m_active = 4'd5; m_pend = 1'b1;
        check("irq_masked", 32'(bus.irq), 32'd0);
        rd(2'd0, status_exp());
        wr(2'd2, 32'h1);
        m_pend = 1'b0;
        rd(2'd0, status_exp());

        // Bouncing pins faster than the debounce window.
        r0 = req_rises;
        for (int i = 0; i < 8; i++) begin
            set_mode((i % 2 == 0) ? 4'd3 : 4'd5);
            if (i == 5) begin
                rd(2'd0, 32'h50, 32'hF0);
                cyc(3);
            end else begin
                cyc(4);
            end
        end
        cyc(D + 8);
        check("bounce_no_req", 32'(req_rises), 32'(r0));
        rd(2'd0, status_exp());

        // Interrupt enable, then W1C.
        wr(2'd1, 32'h3);
        m_irq_en = 1'b1;
        rd(2'd1, 32'h3);
        req_exp_q.push_back(4'd9);
        set_mode(4'd9);
        wait_quiet(200);
        m_stable = 4'd9; m_active = 4'd9; m_pend = 1'b1;
        check("irq_set", 32'(bus.irq), 32'd1);
        wr(2'd2, 32'h1);
        m_pend = 1'b0;
        check("irq_cleared", 32'(bus.irq), 32'd0);
        rd(2'd0, status_exp());

        // Ack timeout sets error and blocks further sequences until cleared.
        ack_auto = 1'b0;
        req_exp_q.push_back(4'd6);
        set_mode(4'd6);
        wait_req(D + 20);
        dur = 1;
        for (int i = 0; i < int'(T) + 20; i++) begin
            @(posedge clk);
            #1;
            if (!bus.cfg_req) break;
            dur++;
        end
        check("timeout_len_ok", 32'(dur >= int'(T) && dur <= int'(T) + 1), 32'd1);
        wait_quiet(200);
        m_stable = 4'd6; m_error = 1'b1;
        rd(2'd0, status_exp());
        check("timeout_irq", 32'(bus.irq), 32'd0);
        ack_auto = 1'b1;
        r0 = req_rises;
        set_mode(4'd2);
        cyc(D + 10);
        m_stable = 4'd2;
        check("error_blocks", 32'(req_rises), 32'(r0));
        rd(2'd0, status_exp());
        req_exp_q.push_back(4'd2);
        wr(2'd2, 32'h2);
        m_error = 1'b0;
        wait_quiet(200);
        m_active = 4'd2; m_pend = 1'b1;
        rd(2'd0, status_exp());
        wr(2'd2, 32'h1);
        m_pend = 1'b0;

        // Ack outside WAIT_ACK has no effect.
        stray_ack = 1'b1;
        cyc(4);
        rd(2'd0, status_exp());

        // Mode change while waiting for ack is serviced afterwards.
        ack_dly = 30;
        req_exp_q.push_back(4'd1);
        set_mode(4'd1);
        wait_req(D + 20);
        req_exp_q.push_back(4'd7);
        set_mode(4'd7);
        wait_quiet(300);
        ack_dly = 3;
        m_stable = 4'd7; m_active = 4'd7; m_pend = 1'b1;
        rd(2'd0, status_exp());
        wr(2'd2, 32'h1);
        m_pend = 1'b0;

        // Disabled controller holds off until enabled.
        wr(2'd1, 32'h2);
        rd(2'd1, 32'h2);
        r0 = req_rises;
        set_mode(4'd12);
        cyc(D + 10);
        m_stable = 4'd12;
        check("disable_blocks", 32'(req_rises), 32'(r0));
        rd(2'd0, status_exp());
        req_exp_q.push_back(4'd12);
        wr(2'd1, 32'h3);
        wait_quiet(200);
        m_active = 4'd12; m_pend = 1'b1;
        check("irq_after_enable", 32'(bus.irq), 32'd1);
        wr(2'd2, 32'h1);
        m_pend = 1'b0;

        // Reserved address.
        wr(2'd3, 32'hFFFF_FFFF);
        rd(2'd1, 32'h3);
        rd(2'd3, 32'd0);
        rd(2'd2, 32'd0);

        // Randomised mode changes.
        for (int it = 0; it < 10; it++) begin
            nm      = 4'($urandom_range(0, 15));
            ie      = 1'($urandom_range(0, 1));
            ack_dly = int'($urandom_range(2, 6));
            wr(2'd1, {30'b0, ie, 1'b1});
            m_irq_en = ie;
            if (nm != m_active) req_exp_q.push_back(nm);
            set_mode(nm);
            wait_quiet(300);
            if (nm != m_active) begin
                m_active = nm;
                m_pend   = 1'b1;
            end
            m_stable = nm;
            check("rand_irq", 32'(bus.irq), 32'(m_pend & m_irq_en));
            rd(2'd0, status_exp());
            if ($urandom_range(0, 1) == 1) begin
                wr(2'd2, 32'h1);
                m_pend = 1'b0;
            end
        end

        // Asynchronous reset in WAIT_ACK.
        ack_auto = 1'b0;
        nm = ~m_active;
        req_exp_q.push_back(nm);
        set_mode(nm);
        wait_req(D + 20);
        cyc(3);
        reset       = 1'b1;
        bus.mode_in = '0;
        #1;
        check("async_rst_req", 32'(bus.cfg_req), 32'd0);
        check("async_rst_blank", 32'(bus.video_blank), 32'd0);
        check("async_rst_rdata", bus.avs_readdata, 32'd0);
        cyc(3);
        reset    = 1'b0;
        ack_auto = 1'b1;
        m_pins = '0; m_stable = '0; m_active = '0;
        m_error = 1'b0; m_pend = 1'b0; m_irq_en = 1'b0;
        rd(2'd0, status_exp());
        rd(2'd1, 32'd1);
        r0 = req_rises;
        cyc(D + 10);
        check("post_rst_idle", 32'(req_rises), 32'(r0));

        cyc(2);
        check("rd_queue_drained", 32'(rd_exp_q.size()), 32'd0);
        check("req_queue_drained", 32'(req_exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
